// File: rtl/swb_isu_arb_pkg.sv
// Shared store-write-buffer definitions.
// The buffer and the issue arbiter both import these, so entry count and widths always agree.
package swb_isu_arb_pkg;

    localparam int unsigned SWB_DEPTH_DEF = 8;
    localparam int unsigned SWB_ID_W_DEF  = $clog2(SWB_DEPTH_DEF);
    localparam int unsigned SWB_DATA_W    = 128;

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker.
// The first request at or after ptr, taken modulo NUM_REQ, wins.
module rr_arb #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic found;
    int   cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = int'(ptr) + i;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            if (!found && req[IDX_W'(cand)]) begin
                found                = 1'b1;
                gnt[IDX_W'(cand)]    = 1'b1;
                idx                  = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/swb_isu_arb.sv
// Store issue arbiter.
// Round-robin grants stores into the store write buffer, tracks credits and registers each write.
module swb_isu_arb
    import swb_isu_arb_pkg::*;
#(
    parameter int unsigned SWB_DEPTH = SWB_DEPTH_DEF,
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned SWB_ID_W  = $clog2(SWB_DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][SWB_DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 d_rc_valid,
    output logic [SWB_ID_W-1:0]                  d_rc_swb_id,
    output logic [SWB_DATA_W-1:0]                d_rc_data,
    input  logic                                 d_isu_crdt_rtn,
    output logic [SWB_ID_W:0]                    crdt_cnt,
    output logic                                 swb_full,
    output logic                                 swb_empty,
    output logic                                 crdt_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [SWB_ID_W:0] CRDT_MAX = (SWB_ID_W + 1)'(SWB_DEPTH);

    logic [SWB_ID_W:0]       crdt_q, crdt_d;
    logic [SWB_ID_W-1:0]     alloc_q;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    vld_q;
    logic [SWB_ID_W-1:0]     id_q;
    logic [SWB_DATA_W-1:0]   data_q;
    logic                    err_q, err_d;
    logic                    rtn_q;

    logic [NUM_REQ-1:0]      pick_gnt;
    logic [IDX_W-1:0]        pick_idx;
    logic                    grant;
    logic                    rtn_edge;

    rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Gate on the registered count so a credit returned this cycle is not spent this cycle.
    assign req_ready = (rstn && crdt_q != '0) ? pick_gnt : '0;
    assign grant     = |req_ready;
    assign rtn_edge  = d_isu_crdt_rtn & ~rtn_q;

    always_comb begin
        crdt_d   = crdt_q;
        err_d    = err_q;
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
        unique case ({grant, rtn_edge})
            2'b10: crdt_d = crdt_q - 1'b1;
            2'b01: begin
                if (crdt_q == CRDT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    crdt_d = crdt_q + 1'b1;
                end
            end
            default: crdt_d = crdt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crdt_q   <= CRDT_MAX;
            alloc_q  <= '0;
            rr_ptr_q <= '0;
            vld_q    <= 1'b0;
            id_q     <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            rtn_q    <= 1'b0;
        end else begin
            crdt_q   <= crdt_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            rtn_q    <= d_isu_crdt_rtn;
            vld_q    <= grant;
            if (grant) begin
                // Power-of-two depth: natural wrap tracks the buffer's in-order drain pointer.
                alloc_q <= alloc_q + 1'b1;
                id_q    <= alloc_q;
                data_q  <= req_data[pick_idx];
            end
        end
    end

    assign d_rc_valid  = vld_q;
    assign d_rc_swb_id = id_q;
    assign d_rc_data   = data_q;
    assign crdt_cnt    = crdt_q;
    assign swb_full    = (crdt_q == '0);
    assign swb_empty   = (crdt_q == CRDT_MAX);
    assign crdt_err    = err_q;

endmodule

// File: tb/tb_swb_isu_arb.sv
// Directed bench for swb_isu_arb at SWB_DEPTH=8, NUM_REQ=2.
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_swb_isu_arb;

    localparam logic [127:0] D0 = 128'hA0A0_0000_1111_2222_3333_4444_5555_0000;
    localparam logic [127:0] D1 = 128'hB1B1_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_0001;

    logic             clk;
    logic             rstn;
    logic [1:0]       req_valid;
    logic [1:0][127:0] req_data;
    logic [1:0]       req_ready;
    logic             d_rc_valid;
    logic [2:0]       d_rc_swb_id;
    logic [127:0]     d_rc_data;
    logic             d_isu_crdt_rtn;
    logic [3:0]       crdt_cnt;
    logic             swb_full;
    logic             swb_empty;
    logic             crdt_err;

    int checks;
    int failures;

    swb_isu_arb #(
        .SWB_DEPTH (8),
        .NUM_REQ   (2)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .d_rc_valid     (d_rc_valid),
        .d_rc_swb_id    (d_rc_swb_id),
        .d_rc_data      (d_rc_data),
        .d_isu_crdt_rtn (d_isu_crdt_rtn),
        .crdt_cnt       (crdt_cnt),
        .swb_full       (swb_full),
        .swb_empty      (swb_empty),
        .crdt_err       (crdt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid      = 2'b00;
        d_isu_crdt_rtn = 1'b0;
        rstn           = 1'b0;
        step();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        req_valid      = 2'b11;
        d_isu_crdt_rtn = 1'b0;
        rstn           = 1'b0;
        step();
        checks++;
        if (req_ready !== 2'b00) begin
            $display("FAIL reset_ready got=%b exp=00", req_ready); failures++;
        end
        checks++;
        if (crdt_cnt !== 4'd8 || swb_empty !== 1'b1 || swb_full !== 1'b0) begin
            $display("FAIL reset_crdt got cnt=%0d empty=%b full=%b exp cnt=8 empty=1 full=0",
                     crdt_cnt, swb_empty, swb_full);
            failures++;
        end
        checks++;
        if (d_rc_valid !== 1'b0 || d_rc_swb_id !== 3'd0 || d_rc_data !== 128'd0 ||
            crdt_err !== 1'b0) begin
            $display("FAIL reset_out got vld=%b id=%0d data=%h err=%b exp all zero",
                     d_rc_valid, d_rc_swb_id, d_rc_data, crdt_err);
            failures++;
        end
        req_valid = 2'b00;
        rstn      = 1'b1;
        #1;
    endtask

    task automatic test_credit_drain();
        do_reset();
        req_valid = 2'b01;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (req_ready !== 2'b01) begin
                $display("FAIL drain_ready[%0d] got=%b exp=01", k, req_ready); failures++;
            end
            step();
            checks++;
            if (d_rc_valid !== 1'b1 || d_rc_swb_id !== 3'(k) || d_rc_data !== D0 ||
                crdt_cnt !== 4'(7 - k)) begin
                $display("FAIL drain_wr[%0d] got vld=%b id=%0d cnt=%0d exp vld=1 id=%0d cnt=%0d",
                         k, d_rc_valid, d_rc_swb_id, crdt_cnt, k, 7 - k);
                failures++;
            end
        end
        #1;
        checks++;
        if (req_ready !== 2'b00 || swb_full !== 1'b1) begin
            $display("FAIL drain_full got ready=%b full=%b exp ready=00 full=1",
                     req_ready, swb_full);
            failures++;
        end
        step();
        checks++;
        if (d_rc_valid !== 1'b0 || crdt_cnt !== 4'd0 || d_rc_swb_id !== 3'd7) begin
            $display("FAIL drain_stall got vld=%b cnt=%0d id=%0d exp vld=0 cnt=0 id=7",
                     d_rc_valid, crdt_cnt, d_rc_swb_id);
            failures++;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_fairness();
        logic [1:0]   exp_rdy;
        logic [127:0] exp_d;
        do_reset();
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d   = (k % 2 == 0) ? D0 : D1;
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin
                $display("FAIL fair_ready[%0d] got=%b exp=%b", k, req_ready, exp_rdy);
                failures++;
            end
            step();
            checks++;
            if (d_rc_valid !== 1'b1 || d_rc_data !== exp_d || d_rc_swb_id !== 3'(k)) begin
                $display("FAIL fair_wr[%0d] got vld=%b id=%0d data=%h exp id=%0d data=%h",
                         k, d_rc_valid, d_rc_swb_id, d_rc_data, k, exp_d);
                failures++;
            end
        end
        req_valid = 2'b00;
        step();
        checks++;
        if (crdt_cnt !== 4'd4 || d_rc_valid !== 1'b0 || d_rc_data !== D1) begin
            $display("FAIL fair_idle got cnt=%0d vld=%b data=%h exp cnt=4 vld=0 data=%h",
                     crdt_cnt, d_rc_valid, d_rc_data, D1);
            failures++;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_valid = 2'b01;
        repeat (5) step();
        req_valid = 2'b00;
        step();
        checks++;
        if (crdt_cnt !== 4'd3) begin
            $display("FAIL simul_pre got=%0d exp=3", crdt_cnt); failures++;
        end
        req_valid      = 2'b01;
        d_isu_crdt_rtn = 1'b1;
        step();
        checks++;
        if (crdt_cnt !== 4'd3 || d_rc_valid !== 1'b1 || d_rc_swb_id !== 3'd5) begin
            $display("FAIL simul_both got cnt=%0d vld=%b id=%0d exp cnt=3 vld=1 id=5",
                     crdt_cnt, d_rc_valid, d_rc_swb_id);
            failures++;
        end
        req_valid      = 2'b00;
        d_isu_crdt_rtn = 1'b0;
        step();
        checks++;
        if (crdt_cnt !== 4'd3) begin
            $display("FAIL simul_fall got=%0d exp=3", crdt_cnt); failures++;
        end
    endtask

    task automatic test_level_return();
        do_reset();
        req_valid = 2'b01;
        repeat (3) step();
        req_valid      = 2'b00;
        d_isu_crdt_rtn = 1'b1;
        step();
        checks++;
        if (crdt_cnt !== 4'd6) begin
            $display("FAIL level_first got=%0d exp=6", crdt_cnt); failures++;
        end
        repeat (3) step();
        d_isu_crdt_rtn = 1'b0;
        step();
        checks++;
        if (crdt_cnt !== 4'd6 || crdt_err !== 1'b0) begin
            $display("FAIL level_held got cnt=%0d err=%b exp cnt=6 err=0", crdt_cnt, crdt_err);
            failures++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        d_isu_crdt_rtn = 1'b1;
        step();
        checks++;
        if (crdt_cnt !== 4'd8 || crdt_err !== 1'b1) begin
            $display("FAIL ovf_set got cnt=%0d err=%b exp cnt=8 err=1", crdt_cnt, crdt_err);
            failures++;
        end
        d_isu_crdt_rtn = 1'b0;
        req_valid      = 2'b10;
        repeat (3) step();
        req_valid = 2'b00;
        checks++;
        if (crdt_err !== 1'b1 || crdt_cnt !== 4'd5) begin
            $display("FAIL ovf_sticky got err=%b cnt=%0d exp err=1 cnt=5", crdt_err, crdt_cnt);
            failures++;
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (crdt_err !== 1'b0 || crdt_cnt !== 4'd8) begin
            $display("FAIL ovf_clear got err=%b cnt=%0d exp err=0 cnt=8", crdt_err, crdt_cnt);
            failures++;
        end
        step();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_wrap_and_reset();
        int exp_cnt;
        do_reset();
        exp_cnt   = 8;
        req_valid = 2'b01;
        for (int k = 0; k < 10; k++) begin
            // Returns on odd cycles, each a fresh rising edge coinciding with a grant.
            d_isu_crdt_rtn = (k % 2 == 1);
            if (k % 2 == 0) exp_cnt = exp_cnt - 1;
            step();
            checks++;
            if (d_rc_valid !== 1'b1 || d_rc_swb_id !== 3'(k % 8) || crdt_cnt !== 4'(exp_cnt)) begin
                $display("FAIL wrap[%0d] got vld=%b id=%0d cnt=%0d exp vld=1 id=%0d cnt=%0d",
                         k, d_rc_valid, d_rc_swb_id, crdt_cnt, k % 8, exp_cnt);
                failures++;
            end
        end
        d_isu_crdt_rtn = 1'b0;
        rstn           = 1'b0;
        #1;
        checks++;
        if (d_rc_valid !== 1'b0 || crdt_cnt !== 4'd8 || req_ready !== 2'b00) begin
            $display("FAIL midrst got vld=%b cnt=%0d ready=%b exp vld=0 cnt=8 ready=00",
                     d_rc_valid, crdt_cnt, req_ready);
            failures++;
        end
        step();
        rstn = 1'b1;
        #1;
        checks++;
        if (d_rc_valid !== 1'b0 || req_ready !== 2'b01) begin
            $display("FAIL midrst_rel got vld=%b ready=%b exp vld=0 ready=01",
                     d_rc_valid, req_ready);
            failures++;
        end
        step();
        checks++;
        if (d_rc_valid !== 1'b1 || d_rc_swb_id !== 3'd0 || crdt_cnt !== 4'd7) begin
            $display("FAIL midrst_next got vld=%b id=%0d cnt=%0d exp vld=1 id=0 cnt=7",
                     d_rc_valid, d_rc_swb_id, crdt_cnt);
            failures++;
        end
        req_valid = 2'b00;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rstn           = 1'b0;
        req_valid      = 2'b00;
        d_isu_crdt_rtn = 1'b0;
        req_data[0]    = D0;
        req_data[1]    = D1;
        #2;
        test_reset();
        test_credit_drain();
        test_fairness();
        test_simultaneous();
        test_level_return();
        test_overflow();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/swb_isu_arb.md
SWB_ISU_ARB -- requirements
Module: swb_isu_arb

Interface
REQ-001 SHALL have parameter SWB_DEPTH, default 8: number of store write buffer entries (power of two, >=2).
REQ-002 SHALL have parameter NUM_REQ, default 2: number of store requesters (2..4).
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ: per-requester store request.
REQ-006 SHALL have port req_data, input, NUM_REQ x 128: per-requester store data.
REQ-007 SHALL have port req_ready, output, NUM_REQ: one-hot grant, combinational, at most one bit high.
REQ-008 SHALL have port d_rc_valid, output, 1: registered write strobe into the buffer.
REQ-009 SHALL have port d_rc_swb_id, output, $clog2(SWB_DEPTH): entry index for the write.
REQ-010 SHALL have port d_rc_data, output, 128: data for the write.
REQ-011 SHALL have port d_isu_crdt_rtn, input, 1: credit-return level from the buffer; one rising edge per drained entry.
REQ-012 SHALL have port crdt_cnt, output, $clog2(SWB_DEPTH)+1: free credits available.
REQ-013 SHALL have port swb_full, output, 1: high when crdt_cnt==0.
REQ-014 SHALL have port swb_empty, output, 1: high when crdt_cnt==SWB_DEPTH.
REQ-015 SHALL have port crdt_err, output, 1: sticky error flag.

Function
REQ-016 SHALL grant only when crdt_cnt>0 and at least one req_valid is high; handshake is req_valid&req_ready on the same cycle.
REQ-017 SHALL arbitrate round-robin: search starts at rr_ptr, the first valid index at or after rr_ptr (mod NUM_REQ) wins.
REQ-018 SHALL set rr_ptr to (winner+1) mod NUM_REQ after a grant; rr_ptr SHALL hold when there is no grant.
REQ-019 SHALL register the granted transfer: a grant in cycle N SHALL produce d_rc_valid=1 in cycle N+1 with the winner's data and the current alloc_id.
REQ-020 SHALL drive d_rc_valid=0 in any cycle that follows a no-grant cycle; d_rc_swb_id and d_rc_data SHALL hold their last values.
REQ-021 SHALL keep alloc_id, which increments by 1 per grant and wraps from SWB_DEPTH-1 to 0, so that IDs match the buffer's in-order drain pointer.
REQ-022 SHALL detect a credit return as a rising edge of d_isu_crdt_rtn (a 1-cycle delayed copy that was 0 and a current value of 1); a held level SHALL count once.
REQ-023 SHALL update credits as follows: grant only -> -1; return only -> +1; grant and return in the same cycle -> unchanged.
REQ-024 SHALL NOT allow a returned credit to be used for a grant in the cycle it arrives; the grant gate uses the registered crdt_cnt.
REQ-025 SHALL, on a return with crdt_cnt==SWB_DEPTH and no grant, hold crdt_cnt, set crdt_err, and keep it set until reset.
REQ-026 SHALL drive swb_full, swb_empty and crdt_cnt from registered state only.

Reset
REQ-027 SHALL, while rstn=0, asynchronously set: crdt_cnt=SWB_DEPTH, alloc_id=0, rr_ptr=0, d_rc_valid=0, d_rc_swb_id=0, d_rc_data=0, crdt_err=0, return-edge register=0.
REQ-028 SHALL force req_ready=0 while rstn=0.
REQ-029 SHALL drop any pending registered write on reset mid-operation; no d_rc_valid pulse SHALL follow reset release without a new grant.

Structure
REQ-030 SHALL take SWB_DEPTH, SWB_ID_W=$clog2(SWB_DEPTH) and SWB_DATA_W=128 from the shared define package so that the buffer and this block agree.
REQ-031 SHALL implement the round-robin picker as one sub-module, rr_arb (inputs: req vector and pointer; outputs: one-hot grant and winner index).

Verification
REQ-032 Credit drain: NUM_REQ=2, req0 held valid, no returns -> 8 grants, d_rc_swb_id 0..7, then swb_full=1 and req_ready=0.
REQ-033 Fairness: both requests valid continuously, credits available -> grants alternate 0,1,0,1 and d_rc_data follows the winner.
REQ-034 Simultaneous: crdt_cnt=3, grant and return rising edge in the same cycle -> crdt_cnt stays 3.
REQ-035 Level return: d_isu_crdt_rtn held high for 4 cycles at crdt_cnt=5 -> crdt_cnt=6 (single increment).
REQ-036 Overflow: return edge at crdt_cnt=8 with no grant -> crdt_cnt=8, crdt_err=1 until rstn is asserted.
REQ-037 Wrap and reset: 10 grants with interleaved returns -> IDs 0..7,0,1; then rstn asserted mid-grant -> d_rc_valid=0, crdt_cnt=8, next grant ID=0.
